// File: rtl/conv3x3_sequencer.sv
// Walks a zero-padded 3x3 window over the pixel RAM in raster order, feeding
// pixel/coefficient pairs to an external MAC and storing its clamped result.
module conv3x3_sequencer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              coeff_we,
  input  logic [3:0]        coeff_idx,
  input  logic [7:0]        coeff_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              mac_clear,
  output logic              mac_enable,
  output logic [7:0]        mac_pixel,
  output logic [7:0]        mac_coeff,
  input  logic [7:0]        mac_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  // Neighbour coordinates carry a sign bit and one headroom bit.
  localparam int CW = ADDR_W + 2;
  localparam logic signed [CW-1:0] W_S    = CW'(IMG_W);
  localparam logic signed [CW-1:0] H_S    = CW'(IMG_H);
  localparam logic [ADDR_W-1:0]    W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]    LAST_X = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0]    LAST_Y = ADDR_W'(IMG_H - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACC, LAST, WRITE} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  x_reg, y_reg;
  logic [3:0]         tap_reg;
  logic               oob_reg;
  logic               done_reg;
  logic [7:0]         coeff_reg [0:8];

  logic                     last_x, last_y;
  logic signed [CW-1:0]     dx, dy, nx, ny;
  logic                     in_range;
  logic [ADDR_W-1:0]        nb_addr;

  assign last_x = (x_reg == LAST_X);
  assign last_y = (y_reg == LAST_Y);
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      tap_reg   <= '0;
      oob_reg   <= 1'b0;
      done_reg  <= 1'b0;
      for (int i = 0; i < 9; i++) coeff_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == WRITE) && last_x && last_y;
      // Remembers a skipped read so the matching MAC operand is zeroed.
      oob_reg   <= ~rd_en;
      if (state_reg == IDLE && coeff_we && coeff_idx <= 4'd8)
        coeff_reg[coeff_idx] <= coeff_data;
      if (state_reg == IDLE || state_reg == WRITE)
        tap_reg <= '0;
      else
        tap_reg <= tap_reg + 4'd1;
      if (state_reg == WRITE) begin
        if (last_x) begin
          x_reg <= '0;
          y_reg <= last_y ? '0 : y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = ACC;
      ACC:     if (tap_reg == 4'd8) state_next = LAST;
      LAST:    state_next = WRITE;
      WRITE:   state_next = (last_x && last_y) ? IDLE : CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Tap k maps to dy = k/3 - 1, dx = k%3 - 1.
  always_comb begin
    dx = '0;
    dy = '0;
    case (tap_reg)
      4'd0, 4'd3, 4'd6: dx = '1;
      4'd2, 4'd5, 4'd8: dx = CW'(1);
      default:          dx = '0;
    endcase
    if (tap_reg < 4'd3)
      dy = '1;
    else if (tap_reg >= 4'd6)
      dy = CW'(1);
    nx       = $signed({2'b00, x_reg}) + dx;
    ny       = $signed({2'b00, y_reg}) + dy;
    in_range = !nx[CW-1] && (nx < W_S) && !ny[CW-1] && (ny < H_S);
    nb_addr  = ny[ADDR_W-1:0] * W_A + nx[ADDR_W-1:0];
  end

  always_comb begin
    rd_en      = 1'b0;
    rd_addr    = '0;
    mac_clear  = 1'b0;
    mac_enable = 1'b0;
    mac_pixel  = '0;
    mac_coeff  = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    if (state_reg == CLEAR || state_reg == ACC) begin
      mac_clear = (state_reg == CLEAR);
      rd_en     = in_range;
      if (in_range) rd_addr = nb_addr;
    end
    if (state_reg == ACC || state_reg == LAST) begin
      mac_enable = 1'b1;
      mac_pixel  = oob_reg ? 8'd0 : rd_data;
      mac_coeff  = coeff_reg[tap_reg - 4'd1];
    end
    if (state_reg == WRITE) begin
      wr_en   = 1'b1;
      wr_addr = y_reg * W_A + x_reg;
      wr_data = mac_result;
    end
  end

endmodule

// File: doc/conv3x3_sequencer.md
Name: conv3x3_sequencer

Overview:
- Upstream control stage for the edge-detection MAC.
- Walks a 3x3 window over a W x H 8-bit greyscale image held in a synchronous-read pixel RAM.
- Streams pixel/coefficient pairs into the MAC under mac_clear/mac_enable, then writes the MAC's clamped 8-bit result to the output image RAM.
- Zero padding at image borders; output image is the same size as the input.

Parameters:
- IMG_W, 8, image width in pixels (>=2)
- IMG_H, 8, image height in pixels (>=2)
- ADDR_W, 6, address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that starts a frame; ignored while busy
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final output write
- coeff_we  in  1  kernel coefficient write strobe
- coeff_idx  in  4  tap index 0..8; writes with idx>8 are ignored
- coeff_data  in  8  signed coefficient
- rd_en  out  1  pixel RAM read enable
- rd_addr  out  ADDR_W  pixel RAM address, y*IMG_W+x
- rd_data  in  8  unsigned pixel, valid the cycle after rd_en
- mac_clear  out  1  to MAC clear
- mac_enable  out  1  to MAC enable
- mac_pixel  out  8  to MAC unsigned operand
- mac_coeff  out  8  to MAC signed operand
- mac_result  in  8  from MAC, clamped 0..255
- wr_en  out  1  output RAM write strobe
- wr_addr  out  ADDR_W  output RAM address
- wr_data  out  8  output pixel

Behaviour:
- Reset (async):
  - state IDLE; all outputs 0; x, y, tap counters 0.
  - All 9 coefficients are cleared to 0.
  - Reset mid-frame aborts immediately; no further rd_en/wr_en; done is not pulsed.
- Kernel:
  - 9 signed 8-bit registers, row-major: tap k = 3*(dy+1)+(dx+1), dy,dx in {-1,0,1}.
  - Writes are accepted only in IDLE; coeff_we while busy is ignored.
- Frame:
  - start in IDLE sets busy next cycle.
  - Pixels are processed raster order, x fastest, (0,0) first.
- Per-pixel schedule: 11 cycles, so a frame takes 11*IMG_W*IMG_H cycles.
  - c0 CLEAR: mac_clear=1, mac_enable=0; read issued for tap 0.
  - c1..c8 ACC: mac_enable=1, mac_pixel = pixel of tap k-1, mac_coeff = coeff[k-1]; read issued for tap k.
  - c9 LAST: mac_enable=1 with tap 8; no read.
  - c10 WRITE: wr_en=1, wr_addr = y*IMG_W+x, wr_data = mac_result. The MAC accumulator is settled here. Counters then advance.
  - After the WRITE of (IMG_W-1, IMG_H-1): done=1 for one cycle, busy=0 the same cycle, return to IDLE.
- Read issue:
  - Neighbour (x+dx, y+dy) in range: rd_en=1, rd_addr = (y+dy)*IMG_W+(x+dx).
  - Neighbour out of range (x+dx<0, x+dx>=IMG_W, or same for y): rd_en=0, and the matching mac_pixel next cycle is forced to 0. mac_enable is still asserted, so the cycle count is unchanged.
- Output defaults:
  - mac_clear, mac_enable, rd_en, wr_en are 0 outside the cycles listed above.
  - mac_pixel and mac_coeff are 0 when mac_enable=0.
- Arithmetic (in MAC): sum of 9 products, clamp to 0..255. This block does no arithmetic beyond address computation.
- Address arithmetic uses signed neighbour coordinates, with no wrap-around across row edges.
- start coinciding with the last WRITE cycle is ignored; a new frame needs start in IDLE.

Test Plan:
- Identity kernel (coeff[4]=1, others 0), input pixel(x,y)=8*y+x on 8x8 -> output equals input at every address; done after exactly 704 cycles.
- All-ones kernel, uniform input 20 -> interior outputs 180, edge non-corner 120, corners 80 (zero padding).
- Laplacian (centre 8, others -1), uniform input 100 -> interior 0; corner 800-300=500, clamps to 255.
- Protocol check on pixel (0,0): rd_en low for taps 0,1,2,3,6; mac_pixel=0 in the following cycle for each; mac_clear only in c0; mac_enable high for 9 consecutive cycles.
- coeff_we mid-frame writing idx 4 = 5 -> kernel unchanged, frame output identical to baseline; coeff_idx=9 write in IDLE -> no register changes.
- Reset asserted during pixel (3,2) ACC phase -> all outputs 0 asynchronously, busy=0, no done pulse; a subsequent start reruns the frame from (0,0) with coefficients 0 (all outputs 0).
